// File: rtl/vmem_arbiter.sv
// Two-requester arbiter for the single CPU-side video memory port.
// Round-robin or fixed priority, with a capped grant-lock for short bursts.
module vmem_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int FIXED_PRIO = 0,
  parameter int MAX_BURST  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rq0_valid,
  output logic                    rq0_ready,
  input  logic                    rq0_lock,
  input  logic [DATA_WIDTH/8-1:0] rq0_we,
  input  logic [ADDR_WIDTH-1:0]   rq0_addr,
  input  logic [DATA_WIDTH-1:0]   rq0_wdata,
  output logic                    rs0_valid,
  output logic [DATA_WIDTH-1:0]   rs0_rdata,
  input  logic                    rq1_valid,
  output logic                    rq1_ready,
  input  logic                    rq1_lock,
  input  logic [DATA_WIDTH/8-1:0] rq1_we,
  input  logic [ADDR_WIDTH-1:0]   rq1_addr,
  input  logic [DATA_WIDTH-1:0]   rq1_wdata,
  output logic                    rs1_valid,
  output logic [DATA_WIDTH-1:0]   rs1_rdata,
  output logic                    mem_en,
  output logic [DATA_WIDTH/8-1:0] mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_write,
  input  logic [DATA_WIDTH-1:0]   mem_read
);

  typedef enum logic [1:0] {
    LOCK_NONE,
    LOCK_RQ0,
    LOCK_RQ1
  } lock_owner_t;

  localparam logic [3:0] MAX_CNT = 4'(MAX_BURST);

  lock_owner_t lock_owner, lock_owner_n;
  logic [3:0]  burst_cnt, burst_cnt_n;
  logic        last_grant, last_grant_n;
  logic        rs0_valid_n, rs1_valid_n;

  logic        gnt_valid;
  logic        gnt_id;
  logic        gnt_lock;
  lock_owner_t gnt_owner;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_owner <= LOCK_NONE;
      burst_cnt  <= '0;
      last_grant <= 1'b1;
      rs0_valid  <= 1'b0;
      rs1_valid  <= 1'b0;
    end else begin
      lock_owner <= lock_owner_n;
      burst_cnt  <= burst_cnt_n;
      last_grant <= last_grant_n;
      rs0_valid  <= rs0_valid_n;
      rs1_valid  <= rs1_valid_n;
    end
  end

  // An unexpired lock beats normal arbitration only while its owner still requests.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_id    = 1'b0;
    if (lock_owner == LOCK_RQ0 && rq0_valid && burst_cnt < MAX_CNT) begin
      gnt_valid = 1'b1;
      gnt_id    = 1'b0;
    end else if (lock_owner == LOCK_RQ1 && rq1_valid && burst_cnt < MAX_CNT) begin
      gnt_valid = 1'b1;
      gnt_id    = 1'b1;
    end else if (rq0_valid && rq1_valid) begin
      gnt_valid = 1'b1;
      gnt_id    = (FIXED_PRIO != 0) ? 1'b0 : ~last_grant;
    end else if (rq0_valid) begin
      gnt_valid = 1'b1;
      gnt_id    = 1'b0;
    end else if (rq1_valid) begin
      gnt_valid = 1'b1;
      gnt_id    = 1'b1;
    end
  end

  assign gnt_lock  = gnt_id ? rq1_lock : rq0_lock;
  assign gnt_owner = gnt_id ? LOCK_RQ1 : LOCK_RQ0;

  assign rq0_ready = gnt_valid & ~gnt_id;
  assign rq1_ready = gnt_valid &  gnt_id;

  assign mem_en    = gnt_valid;
  assign mem_we    = !gnt_valid ? '0 : (gnt_id ? rq1_we    : rq0_we);
  assign mem_addr  = !gnt_valid ? '0 : (gnt_id ? rq1_addr  : rq0_addr);
  assign mem_write = !gnt_valid ? '0 : (gnt_id ? rq1_wdata : rq0_wdata);

  assign rs0_rdata = mem_read;
  assign rs1_rdata = mem_read;

  // Any cycle without an accepted locked request releases the lock.
  always_comb begin
    last_grant_n = last_grant;
    lock_owner_n = LOCK_NONE;
    burst_cnt_n  = '0;
    rs0_valid_n  = 1'b0;
    rs1_valid_n  = 1'b0;
    if (gnt_valid) begin
      last_grant_n = gnt_id;
      rs0_valid_n  = ~gnt_id;
      rs1_valid_n  = gnt_id;
      if (gnt_lock) begin
        lock_owner_n = gnt_owner;
        if (lock_owner == gnt_owner && burst_cnt < MAX_CNT)
          burst_cnt_n = burst_cnt + 4'd1;
        else
          burst_cnt_n = 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_vmem_arbiter.sv
// Directed bench for vmem_arbiter: a round-robin instance on a read-first BRAM model,
// plus a fixed-priority instance sharing the same request inputs.
module tb_vmem_arbiter;

  logic        clk;
  logic        rst;
  logic        rq0_valid, rq0_lock, rq1_valid, rq1_lock;
  logic [3:0]  rq0_we, rq1_we;
  logic [15:0] rq0_addr, rq1_addr;
  logic [31:0] rq0_wdata, rq1_wdata;

  logic        rq0_ready, rq1_ready, rs0_valid, rs1_valid, mem_en;
  logic [31:0] rs0_rdata, rs1_rdata, mem_write, mem_read;
  logic [3:0]  mem_we;
  logic [15:0] mem_addr;

  logic        fp_rq0_ready, fp_rq1_ready, fp_rs0_valid, fp_rs1_valid, fp_mem_en;
  logic [31:0] fp_rs0_rdata, fp_rs1_rdata, fp_mem_write;
  logic [31:0] fp_mem_read;
  logic [3:0]  fp_mem_we;
  logic [15:0] fp_mem_addr;

  logic [31:0] bram [0:255];

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        v0, l0;
    logic [3:0]  we0;
    logic [15:0] a0;
    logic [31:0] d0;
    logic        v1, l1;
    logic [3:0]  we1;
    logic [15:0] a1;
    logic [31:0] d1;
    logic        er0, er1;
    logic [3:0]  ewe;
    logic [15:0] eaddr;
    logic [31:0] ewdata;
    logic [31:0] erdata;
  } vec_t;

  vec_t vecs[$];

  vmem_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .FIXED_PRIO(0), .MAX_BURST(4)) dut (
    .clk(clk), .rst(rst),
    .rq0_valid(rq0_valid), .rq0_ready(rq0_ready), .rq0_lock(rq0_lock), .rq0_we(rq0_we),
    .rq0_addr(rq0_addr), .rq0_wdata(rq0_wdata), .rs0_valid(rs0_valid), .rs0_rdata(rs0_rdata),
    .rq1_valid(rq1_valid), .rq1_ready(rq1_ready), .rq1_lock(rq1_lock), .rq1_we(rq1_we),
    .rq1_addr(rq1_addr), .rq1_wdata(rq1_wdata), .rs1_valid(rs1_valid), .rs1_rdata(rs1_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_write(mem_write),
    .mem_read(mem_read)
  );

  vmem_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .FIXED_PRIO(1), .MAX_BURST(4)) dut_fp (
    .clk(clk), .rst(rst),
    .rq0_valid(rq0_valid), .rq0_ready(fp_rq0_ready), .rq0_lock(rq0_lock), .rq0_we(rq0_we),
    .rq0_addr(rq0_addr), .rq0_wdata(rq0_wdata), .rs0_valid(fp_rs0_valid), .rs0_rdata(fp_rs0_rdata),
    .rq1_valid(rq1_valid), .rq1_ready(fp_rq1_ready), .rq1_lock(rq1_lock), .rq1_we(rq1_we),
    .rq1_addr(rq1_addr), .rq1_wdata(rq1_wdata), .rs1_valid(fp_rs1_valid), .rs1_rdata(fp_rs1_rdata),
    .mem_en(fp_mem_en), .mem_we(fp_mem_we), .mem_addr(fp_mem_addr), .mem_write(fp_mem_write),
    .mem_read(fp_mem_read)
  );

  assign fp_mem_read = 32'hFEED_0001;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Read-first synchronous BRAM, preloaded with C0DE_00xx on reset.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_read <= '0;
      for (int i = 0; i < 256; i++) bram[i] <= 32'hC0DE_0000 | 32'(i);
    end else if (mem_en) begin
      mem_read <= bram[mem_addr[7:0]];
      for (int b = 0; b < 4; b++)
        if (mem_we[b]) bram[mem_addr[7:0]][b*8 +: 8] <= mem_write[b*8 +: 8];
    end
  end

  // Expected memory drive is the granted requester's fields, or zeros with no grant.
  function automatic vec_t mk(input logic v0, input logic l0, input logic [3:0] we0,
                              input logic [15:0] a0, input logic [31:0] d0,
                              input logic v1, input logic l1, input logic [3:0] we1,
                              input logic [15:0] a1, input logic [31:0] d1,
                              input logic er0, input logic er1, input logic [31:0] erdata);
    vec_t v;
    v.v0 = v0; v.l0 = l0; v.we0 = we0; v.a0 = a0; v.d0 = d0;
    v.v1 = v1; v.l1 = l1; v.we1 = we1; v.a1 = a1; v.d1 = d1;
    v.er0 = er0; v.er1 = er1; v.erdata = erdata;
    v.ewe    = er0 ? we0 : (er1 ? we1 : 4'h0);
    v.eaddr  = er0 ? a0  : (er1 ? a1  : 16'h0);
    v.ewdata = er0 ? d0  : (er1 ? d1  : 32'h0);
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    rq0_valid = v.v0; rq0_lock = v.l0; rq0_we = v.we0; rq0_addr = v.a0; rq0_wdata = v.d0;
    rq1_valid = v.v1; rq1_lock = v.l1; rq1_we = v.we1; rq1_addr = v.a1; rq1_wdata = v.d1;
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  initial begin
    vec_t idle;
    idle = mk(0, 0, 4'h0, 16'h0, 32'h0, 0, 0, 4'h0, 16'h0, 32'h0, 0, 0, 32'h0);

    rst = 1'b1;
    applyStimulus(idle);

    // Contended reads straight after reset, then single-requester writes and read-backs.
    vecs.push_back(idle);
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(1, 0, 4'h0, 16'h0010, 32'h0, 1, 0, 4'h0, 16'h0011, 32'h0,
                        (i % 2 == 0), (i % 2 == 1),
                        (i % 2 == 0) ? 32'hC0DE_0010 : 32'hC0DE_0011));
    vecs.push_back(idle);
    vecs.push_back(mk(1, 0, 4'b0011, 16'h0004, 32'hAABB_CCDD, 0, 0, 4'h0, 16'h0, 32'h0, 1, 0, 32'hC0DE_0004));
    vecs.push_back(mk(0, 0, 4'h0, 16'h0, 32'h0, 1, 0, 4'h0, 16'h0004, 32'h0, 0, 1, 32'hC0DE_CCDD));
    vecs.push_back(mk(0, 0, 4'h0, 16'h0, 32'h0, 1, 0, 4'hF, 16'h0030, 32'h1234_5678, 0, 1, 32'hC0DE_0030));
    vecs.push_back(mk(0, 0, 4'h0, 16'h0, 32'h0, 1, 0, 4'h0, 16'h0030, 32'h0, 0, 1, 32'h1234_5678));
    // rq1 burst: four locked grants, one to rq0, one more to rq1, then round-robin.
    vecs.push_back(mk(0, 0, 4'h0, 16'h0, 32'h0, 1, 1, 4'h0, 16'h0040, 32'h0, 0, 1, 32'hC0DE_0040));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(1, 0, 4'h0, 16'h0050, 32'h0, 1, 1, 4'h0, 16'h0040, 32'h0, 0, 1, 32'hC0DE_0040));
    vecs.push_back(mk(1, 0, 4'h0, 16'h0050, 32'h0, 1, 1, 4'h0, 16'h0040, 32'h0, 1, 0, 32'hC0DE_0050));
    vecs.push_back(mk(1, 0, 4'h0, 16'h0050, 32'h0, 1, 0, 4'h0, 16'h0040, 32'h0, 0, 1, 32'hC0DE_0040));
    vecs.push_back(mk(1, 0, 4'h0, 16'h0050, 32'h0, 1, 0, 4'h0, 16'h0040, 32'h0, 1, 0, 32'hC0DE_0050));
    vecs.push_back(mk(1, 0, 4'h0, 16'h0050, 32'h0, 1, 0, 4'h0, 16'h0040, 32'h0, 0, 1, 32'hC0DE_0040));
    // rq0 lock beats round-robin, then owner drops valid; idle cycle releases lock.
    vecs.push_back(mk(1, 1, 4'h0, 16'h0060, 32'h0, 0, 0, 4'h0, 16'h0, 32'h0, 1, 0, 32'hC0DE_0060));
    vecs.push_back(mk(1, 1, 4'h0, 16'h0060, 32'h0, 1, 0, 4'h0, 16'h0061, 32'h0, 1, 0, 32'hC0DE_0060));
    vecs.push_back(mk(0, 0, 4'h0, 16'h0060, 32'h0, 1, 0, 4'h0, 16'h0061, 32'h0, 0, 1, 32'hC0DE_0061));
    vecs.push_back(mk(1, 0, 4'h0, 16'h0060, 32'h0, 1, 0, 4'h0, 16'h0061, 32'h0, 1, 0, 32'hC0DE_0060));
    vecs.push_back(mk(1, 1, 4'h0, 16'h0060, 32'h0, 0, 0, 4'h0, 16'h0, 32'h0, 1, 0, 32'hC0DE_0060));
    vecs.push_back(idle);
    vecs.push_back(mk(1, 0, 4'h0, 16'h0060, 32'h0, 1, 0, 4'h0, 16'h0061, 32'h0, 0, 1, 32'hC0DE_0061));
    // Lone owner at the cap restarts its count, so the lock still wins the next contended cycle.
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(1, 1, 4'h0, 16'h0070, 32'h0, 0, 0, 4'h0, 16'h0, 32'h0, 1, 0, 32'hC0DE_0070));
    vecs.push_back(mk(1, 1, 4'h0, 16'h0070, 32'h0, 1, 0, 4'h0, 16'h0071, 32'h0, 1, 0, 32'hC0DE_0070));

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset rs0_valid", 64'(rs0_valid), 64'd0);
    checkOutput("reset rs1_valid", 64'(rs1_valid), 64'd0);
    checkOutput("reset mem_en", 64'(mem_en), 64'd0);
    checkOutput("reset rq0_ready", 64'(rq0_ready), 64'd0);
    rst = 1'b0;

    foreach (vecs[n]) begin
      applyStimulus(vecs[n]);
      checkOutput($sformatf("v%0d rq0_ready", n), 64'(rq0_ready), 64'(vecs[n].er0));
      checkOutput($sformatf("v%0d rq1_ready", n), 64'(rq1_ready), 64'(vecs[n].er1));
      checkOutput($sformatf("v%0d mem_en", n), 64'(mem_en), 64'(vecs[n].er0 | vecs[n].er1));
      checkOutput($sformatf("v%0d mem_we", n), 64'(mem_we), 64'(vecs[n].ewe));
      checkOutput($sformatf("v%0d mem_addr", n), 64'(mem_addr), 64'(vecs[n].eaddr));
      checkOutput($sformatf("v%0d mem_write", n), 64'(mem_write), 64'(vecs[n].ewdata));
      @(posedge clk);
      #1;
      checkOutput($sformatf("v%0d rs0_valid", n), 64'(rs0_valid), 64'(vecs[n].er0));
      checkOutput($sformatf("v%0d rs1_valid", n), 64'(rs1_valid), 64'(vecs[n].er1));
      if (vecs[n].er0)
        checkOutput($sformatf("v%0d rs0_rdata", n), 64'(rs0_rdata), 64'(vecs[n].erdata));
      else if (vecs[n].er1)
        checkOutput($sformatf("v%0d rs1_rdata", n), 64'(rs1_rdata), 64'(vecs[n].erdata));
    end

    // Async reset with an rq1 response pending, then contended grant after release.
    applyStimulus(mk(0, 0, 4'h0, 16'h0, 32'h0, 1, 0, 4'h0, 16'h0011, 32'h0, 0, 1, 32'h0));
    @(posedge clk);
    #1;
    checkOutput("pre-reset rs1_valid", 64'(rs1_valid), 64'd1);
    #1 rst = 1'b1;
    #1;
    checkOutput("async rs1_valid", 64'(rs1_valid), 64'd0);
    checkOutput("async rs0_valid", 64'(rs0_valid), 64'd0);
    rst = 1'b0;
    applyStimulus(mk(1, 0, 4'h0, 16'h0010, 32'h0, 1, 0, 4'h0, 16'h0011, 32'h0, 1, 0, 32'h0));
    checkOutput("post-reset rq0_ready", 64'(rq0_ready), 64'd1);
    checkOutput("post-reset rq1_ready", 64'(rq1_ready), 64'd0);

    // Fixed priority: rq0 holds the port while valid, rq1 gets it the cycle rq0 goes idle.
    for (int i = 0; i < 6; i++) begin
      checkOutput($sformatf("fp c%0d rq0_ready", i), 64'(fp_rq0_ready), 64'd1);
      checkOutput($sformatf("fp c%0d rq1_ready", i), 64'(fp_rq1_ready), 64'd0);
      checkOutput($sformatf("fp c%0d mem_addr", i), 64'(fp_mem_addr), 64'h0010);
      @(posedge clk);
      #1;
      checkOutput($sformatf("fp c%0d rs0_valid", i), 64'(fp_rs0_valid), 64'd1);
      checkOutput($sformatf("fp c%0d rs0_rdata", i), 64'(fp_rs0_rdata), 64'hFEED_0001);
    end
    rq0_valid = 1'b0;
    #1;
    checkOutput("fp drop rq1_ready", 64'(fp_rq1_ready), 64'd1);
    checkOutput("fp drop rq0_ready", 64'(fp_rq0_ready), 64'd0);
    checkOutput("fp drop mem_addr", 64'(fp_mem_addr), 64'h0011);
    checkOutput("fp drop mem_we", 64'(fp_mem_we), 64'd0);
    checkOutput("fp drop mem_write", 64'(fp_mem_write), 64'd0);
    checkOutput("fp drop mem_en", 64'(fp_mem_en), 64'd1);
    @(posedge clk);
    #1;
    checkOutput("fp drop rs1_valid", 64'(fp_rs1_valid), 64'd1);
    checkOutput("fp drop rs0_valid", 64'(fp_rs0_valid), 64'd0);
    checkOutput("fp drop rs1_rdata", 64'(fp_rs1_rdata), 64'hFEED_0001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vmem_arbiter.md
Name: vmem_arbiter

Overview:
- Shares the single CPU-side port of the video memory/control-register window between two bus requesters: requester 0 (CPU bus bridge) and requester 1 (blit/fill engine).
- Grants one access per cycle, drives the memory port directly and returns responses with a fixed one-cycle latency, matching the synchronous BRAM read.
- Supports round-robin or fixed priority, plus a capped grant-lock for short bursts.

Parameters:
- ADDR_WIDTH, 16: request/memory address width (bit 15 selects control registers downstream; this block does not decode it).
- DATA_WIDTH, 32: data width; byte-enable width is DATA_WIDTH/8.
- FIXED_PRIO, 0: 0 = round-robin; 1 = requester 0 always wins when not locked out.
- MAX_BURST, 4: maximum consecutive grants to one requester under lock; range 1..15.

Ports:
- clk  in  1  clock; memory side is on the same clock (wired to mem_clk).
- rst  in  1  reset, asynchronous, active-high.
- rq0_valid  in  1  requester 0 has a request.
- rq0_ready  out  1  request 0 accepted this cycle.
- rq0_lock  in  1  request to keep the grant for the next cycle.
- rq0_we  in  DATA_WIDTH/8  byte write enables; all zero = read.
- rq0_addr  in  ADDR_WIDTH  address.
- rq0_wdata  in  DATA_WIDTH  write data.
- rs0_valid  out  1  response for requester 0.
- rs0_rdata  out  DATA_WIDTH  read data (old contents for writes).
- rq1_* / rs1_*  same as requester 0, for requester 1.
- mem_en  out  1  memory port enable.
- mem_we  out  DATA_WIDTH/8  byte enables.
- mem_addr  out  ADDR_WIDTH  address.
- mem_write  out  DATA_WIDTH  write data.
- mem_read  in  DATA_WIDTH  read data, valid the cycle after mem_en.

Behaviour:
- Reset (async): last_grant=1 (requester 0 wins first), lock_owner=none, burst_cnt=0, rs0_valid=rs1_valid=0, rsp_id=0. Combinational outputs follow from that state: rq*_ready=0 with no valid, mem_en=0.
- Arbitration is combinational within the cycle. gnt is chosen from the valids and registered state.
  - If lock_owner=k, rqk_valid=1 and burst_cnt<MAX_BURST: gnt=k.
  - Else if both valid: with FIXED_PRIO=1, gnt=0; with round-robin, gnt = the requester other than last_grant.
  - Else gnt = the sole valid requester; none if neither is valid.
- rq{gnt}_ready=1 and the other ready=0. The ready never depends on the ready output itself.
- Memory drive: mem_en=1 and mem_we/mem_addr/mem_write = the granted requester's fields. With no grant, mem_en=0, mem_we=0, and address/data are don't-care; drive 0.
- Acceptance (valid & ready at posedge):
  - last_grant<=gnt.
  - rsp pipeline: rs{gnt}_valid<=1 next cycle, the other <=0.
  - No acceptance: both rs*_valid<=0.
- Response: rsK_rdata = mem_read, passed through combinationally; meaningful only while rsK_valid=1. Latency is exactly 1 cycle for every accepted request, reads and writes alike. There is no response backpressure.
- Lock/burst:
  - On acceptance with rq{gnt}_lock=1: if lock_owner==gnt, burst_cnt<=burst_cnt+1; otherwise lock_owner<=gnt and burst_cnt<=1.
  - On acceptance with lock=0: lock_owner<=none, burst_cnt<=0.
  - When burst_cnt reaches MAX_BURST, the lock is ignored and normal arbitration applies. If the other requester wins, lock_owner<=none and burst_cnt<=0. If the owner wins again because it is alone, the count restarts at 1.
  - Lock owner drops valid: lock is released that cycle (lock_owner<=none, burst_cnt<=0) and normal arbitration applies.
- Throughput: one accepted request per cycle, back-to-back, with no bubbles on grant switches.
- Simultaneous events:
  - Both valid under round-robin: strict alternation.
  - Under FIXED_PRIO=1, requester 1 is served only when requester 0 is idle. This starvation is accepted.
- Reset mid-operation: in-flight responses are dropped (rs*_valid=0 immediately). The memory write issued in the cycle before reset is not undone.
- Requesters must hold fields stable while valid and not ready. The arbiter does not check this.

Test Plan:
- Reset then idle, rq0 read addr 0x0010 only -> rq0_ready=1 same cycle, mem_en=1, mem_addr=0x0010, mem_we=0. Next cycle rs0_valid=1, rs0_rdata=mem_read, rs1_valid=0.
- Both valid continuously, FIXED_PRIO=0, starting from reset -> grants 0,1,0,1...; each rsK_valid pulses the cycle after its grant; no idle cycles.
- FIXED_PRIO=1, both valid 6 cycles -> requester 0 granted all 6 and rq1_ready=0. Drop rq0_valid -> rq1 granted that same cycle.
- Lock: rq1 valid+lock continuously, rq0 valid, MAX_BURST=4, rq1 owns first -> rq1 gets 4 consecutive grants, then rq0 gets one, then rq1 gets one, after which round-robin continues.
- Write: rq0_we=4'b0011, addr 0x0004, wdata 0xAABBCCDD -> mem_we=4'b0011 with data passed through. Read-back of 0x0004 by rq1 returns the updated low halfword.
- Async rst asserted while rs1_valid is pending -> rs1_valid=0 without a clock edge. After release, the first contended grant goes to requester 0.
